// File: rtl/axis_noc_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream <-> NoC flit adapters.
package axis_noc_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND
  } ser_state_e;

  // Counter must represent every value 0..depth inclusive.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit divides_evenly(input int unsigned num, input int unsigned den);
    return (den != 0) && ((num % den) == 0);
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter mirroring the free slots of a downstream router input buffer.
module noc_credit_counter
  import axis_noc_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = credit_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          consume,
  input  logic          credit_in,
  output logic [CW-1:0] count,
  output logic          has_credit
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;

  assign w_full     = (r_count == FULL);
  assign w_empty    = (r_count == '0);
  assign count      = r_count;
  assign has_credit = !w_empty;

  // A return and a consume in the same cycle cancel; an excess return saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= FULL;
    end else begin
      case ({credit_in, consume})
        2'b10:   if (!w_full)  r_count <= r_count + 1'b1;
        2'b01:   if (!w_empty) r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  a_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(credit_in && w_full))
    else $error("noc_credit_counter: credit returned while all %0d credits are held", DEPTH);

endmodule

// File: rtl/axis_flit_serializer.sv
// AXI-Stream word to NoC flit serializer with credit-based flow control.
module axis_flit_serializer
  import axis_noc_pkg::*;
#(
  parameter  int unsigned TDEST_WIDTH          = 6,
  parameter  int unsigned TDATA_WIDTH          = 512,
  parameter  int unsigned SERIALIZATION_FACTOR = 4,
  parameter  int unsigned FLIT_BUFFER_DEPTH    = 4,
  localparam int unsigned FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   axis_tvalid,
  output logic                   axis_tready,
  input  logic [TDATA_WIDTH-1:0] axis_tdata,
  input  logic                   axis_tlast,
  input  logic [TDEST_WIDTH-1:0] axis_tdest,
  output logic [FLIT_WIDTH-1:0]  data_out,
  output logic [TDEST_WIDTH-1:0] dest_out,
  output logic                   is_tail_out,
  output logic                   send_out,
  input  logic                   credit_in
);

  localparam int unsigned CREDIT_WIDTH = credit_width(FLIT_BUFFER_DEPTH);
  localparam int unsigned IDX_WIDTH    = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);

  if (!divides_evenly(TDATA_WIDTH, SERIALIZATION_FACTOR)) begin : g_bad_factor
    $error("axis_flit_serializer: SERIALIZATION_FACTOR (%0d) must divide TDATA_WIDTH (%0d)",
           SERIALIZATION_FACTOR, TDATA_WIDTH);
  end
  if (FLIT_BUFFER_DEPTH < 1) begin : g_bad_depth
    $error("axis_flit_serializer: FLIT_BUFFER_DEPTH must be at least 1");
  end

  ser_state_e                                       r_state;
  logic                                             r_ready_en;
  logic [IDX_WIDTH-1:0]                             r_idx;
  logic [SERIALIZATION_FACTOR-1:0][FLIT_WIDTH-1:0] r_word;
  logic [TDEST_WIDTH-1:0]                           r_dest;
  logic                                             r_last;

  logic [CREDIT_WIDTH-1:0] w_credit_count;
  logic                    w_has_credit;
  logic                    w_issue;
  logic                    w_is_last_idx;
  logic                    w_final;
  logic                    w_accept;

  noc_credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .consume    (w_issue),
    .credit_in  (credit_in),
    .count      (w_credit_count),
    .has_credit (w_has_credit)
  );

  // Issue looks only at the registered count; a same-cycle credit is not bypassed.
  assign w_issue       = (r_state == SEND) && w_has_credit;
  assign w_is_last_idx = (r_idx == LAST_IDX);
  assign w_final       = w_issue && w_is_last_idx;
  assign axis_tready   = r_ready_en && ((r_state == IDLE) || w_final);
  assign w_accept      = axis_tvalid && axis_tready;

  // Holds tready low through the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_word  <= '0;
      r_dest  <= '0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_state <= SEND;
      r_idx   <= '0;
      r_word  <= axis_tdata;
      r_dest  <= axis_tdest;
      r_last  <= axis_tlast;
    end else if (w_final) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else if (w_issue) begin
      r_idx   <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= w_issue;
      if (w_issue) begin
        data_out    <= r_word[r_idx];
        dest_out    <= r_dest;
        is_tail_out <= r_last && w_is_last_idx;
      end
    end
  end

  a_credit_flag_consistent: assert property (@(posedge clk) disable iff (!rst_n)
                                              w_has_credit == (w_credit_count != '0))
    else $error("axis_flit_serializer: credit flag disagrees with credit count");

endmodule

// File: tb/tb_axis_flit_serializer.sv
// Directed bench for axis_flit_serializer with 32-bit words split into four 8-bit flits.
module tb_axis_flit_serializer;

  localparam int unsigned TDEST_W = 6;
  localparam int unsigned TDATA_W = 32;
  localparam int unsigned S       = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned FW      = TDATA_W / S;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               axis_tvalid = 1'b0;
  logic               axis_tready;
  logic [TDATA_W-1:0] axis_tdata = '0;
  logic               axis_tlast = 1'b0;
  logic [TDEST_W-1:0] axis_tdest = '0;
  logic [FW-1:0]      data_out;
  logic [TDEST_W-1:0] dest_out;
  logic               is_tail_out;
  logic               send_out;
  logic               credit_in;
  logic               tb_credit = 1'b0;
  logic               loopback = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // In loopback the router model returns a credit for every flit it receives.
  assign credit_in = tb_credit | (loopback & send_out);

  axis_flit_serializer #(
    .TDEST_WIDTH          (TDEST_W),
    .TDATA_WIDTH          (TDATA_W),
    .SERIALIZATION_FACTOR (S),
    .FLIT_BUFFER_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axis_tvalid (axis_tvalid),
    .axis_tready (axis_tready),
    .axis_tdata  (axis_tdata),
    .axis_tlast  (axis_tlast),
    .axis_tdest  (axis_tdest),
    .data_out    (data_out),
    .dest_out    (dest_out),
    .is_tail_out (is_tail_out),
    .send_out    (send_out),
    .credit_in   (credit_in)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_flit(input string tag, input logic [7:0] d, input logic [5:0] dst,
                             input logic tail);
    check_eq({tag, ".send"}, 32'(send_out), 32'd1);
    check_eq({tag, ".data"}, 32'(data_out), 32'(d));
    check_eq({tag, ".dest"}, 32'(dest_out), 32'(dst));
    check_eq({tag, ".tail"}, 32'(is_tail_out), 32'(tail));
  endtask

  task automatic give_credits(input int n);
    for (int i = 0; i < n; i++) begin
      tb_credit = 1'b1;
      step();
    end
    tb_credit = 1'b0;
  endtask

  task automatic present(input logic [31:0] d, input logic last, input logic [5:0] dst);
    axis_tvalid = 1'b1;
    axis_tdata  = d;
    axis_tlast  = last;
    axis_tdest  = dst;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] words [3];
  logic [5:0]  dests [3];
  logic        lasts [3];
  logic [7:0]  exp_d [12];
  logic [5:0]  exp_dst [12];
  logic        exp_t [12];

  initial begin
    int wi, got, first, last_cyc;
    bit accept;
    logic [31:0] w;

    // Reset state and gating of tready
    rst_n = 1'b0;
    repeat (2) step();
    check_eq("rst.send", 32'(send_out), 32'd0);
    check_eq("rst.data", 32'(data_out), 32'd0);
    check_eq("rst.dest", 32'(dest_out), 32'd0);
    check_eq("rst.tail", 32'(is_tail_out), 32'd0);
    check_eq("rst.tready", 32'(axis_tready), 32'd0);
    rst_n = 1'b1;
    check_eq("rel.tready", 32'(axis_tready), 32'd0);
    step();
    check_eq("en.tready", 32'(axis_tready), 32'd1);

    // Single word: handshake in t, flits in t+2..t+5
    present(32'hDDCCBBAA, 1'b1, 6'd5);
    step();
    axis_tvalid = 1'b0;
    check_eq("w1.t1.tready", 32'(axis_tready), 32'd0);
    check_eq("w1.t1.send", 32'(send_out), 32'd0);
    step();
    expect_flit("w1.f0", 8'hAA, 6'd5, 1'b0);
    check_eq("w1.t2.tready", 32'(axis_tready), 32'd0);
    step();
    expect_flit("w1.f1", 8'hBB, 6'd5, 1'b0);
    check_eq("w1.t3.tready", 32'(axis_tready), 32'd0);
    step();
    expect_flit("w1.f2", 8'hCC, 6'd5, 1'b0);
    check_eq("w1.t4.tready", 32'(axis_tready), 32'd1);
    step();
    expect_flit("w1.f3", 8'hDD, 6'd5, 1'b1);
    check_eq("w1.t5.tready", 32'(axis_tready), 32'd1);
    step();
    check_eq("w1.t6.send", 32'(send_out), 32'd0);
    check_eq("w1.hold.data", 32'(data_out), 32'hDD);
    check_eq("w1.hold.tail", 32'(is_tail_out), 32'd1);
    give_credits(4);

    // Credit exhaustion: two words, only four credits
    present(32'h44332211, 1'b0, 6'd12);
    check_eq("ex.t0.tready", 32'(axis_tready), 32'd1);
    step();
    axis_tdata = 32'h88776655;
    check_eq("ex.t1.tready", 32'(axis_tready), 32'd0);
    step();
    expect_flit("ex.a0", 8'h11, 6'd12, 1'b0);
    step();
    expect_flit("ex.a1", 8'h22, 6'd12, 1'b0);
    step();
    expect_flit("ex.a2", 8'h33, 6'd12, 1'b0);
    check_eq("ex.t4.tready", 32'(axis_tready), 32'd1);
    step();
    axis_tvalid = 1'b0;
    expect_flit("ex.a3", 8'h44, 6'd12, 1'b0);
    check_eq("ex.t5.tready", 32'(axis_tready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("ex.stall.send", 32'(send_out), 32'd0);
      check_eq("ex.stall.tready", 32'(axis_tready), 32'd0);
    end
    tb_credit = 1'b1;
    step();
    tb_credit = 1'b0;
    check_eq("ex.c1.send", 32'(send_out), 32'd0);
    step();
    expect_flit("ex.b0", 8'h55, 6'd12, 1'b0);
    step();
    check_eq("ex.c3.send", 32'(send_out), 32'd0);

    // Count at 1 with issue and credit together: flits continue without a gap
    tb_credit = 1'b1;
    step();
    check_eq("sim.c1.send", 32'(send_out), 32'd0);
    step();
    expect_flit("sim.b1", 8'h66, 6'd12, 1'b0);
    step();
    tb_credit = 1'b0;
    expect_flit("sim.b2", 8'h77, 6'd12, 1'b0);
    check_eq("sim.tready", 32'(axis_tready), 32'd1);
    step();
    expect_flit("sim.b3", 8'h88, 6'd12, 1'b0);
    step();
    check_eq("sim.done.send", 32'(send_out), 32'd0);
    give_credits(4);

    // Back-to-back words with credits looped back
    words = '{32'h13121110, 32'h23222120, 32'h33323130};
    dests = '{6'd7, 6'd9, 6'd3};
    lasts = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      w = words[k];
      for (int f = 0; f < 4; f++) begin
        exp_d[k*4+f]   = w[f*8 +: 8];
        exp_dst[k*4+f] = dests[k];
        exp_t[k*4+f]   = lasts[k] && (f == 3);
      end
    end
    loopback = 1'b1;
    wi = 0; got = 0; first = -1; last_cyc = -1;
    present(words[0], lasts[0], dests[0]);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (send_out) begin
        if (got < 12) expect_flit($sformatf("b2b.f%0d", got), exp_d[got], exp_dst[got], exp_t[got]);
        if (first < 0) first = cyc;
        last_cyc = cyc;
        got++;
      end
      accept = axis_tvalid && axis_tready;
      step();
      if (accept) begin
        wi++;
        if (wi < 3) present(words[wi], lasts[wi], dests[wi]);
        else        axis_tvalid = 1'b0;
      end
    end
    loopback = 1'b0;
    check_eq("b2b.count", 32'(got), 32'd12);
    check_eq("b2b.span", 32'(last_cyc - first), 32'd11);

    // Reset in the middle of a word
    present(32'hA4A3A2A1, 1'b1, 6'd2);
    step();
    axis_tvalid = 1'b0;
    step();
    expect_flit("mid.f0", 8'hA1, 6'd2, 1'b0);
    step();
    expect_flit("mid.f1", 8'hA2, 6'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid.rst.send", 32'(send_out), 32'd0);
    check_eq("mid.rst.data", 32'(data_out), 32'd0);
    check_eq("mid.rst.dest", 32'(dest_out), 32'd0);
    check_eq("mid.rst.tail", 32'(is_tail_out), 32'd0);
    check_eq("mid.rst.tready", 32'(axis_tready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    check_eq("mid.rel.tready", 32'(axis_tready), 32'd0);
    step();
    check_eq("mid.en.tready", 32'(axis_tready), 32'd1);
    present(32'hB4B3B2B1, 1'b1, 6'd4);
    step();
    axis_tvalid = 1'b0;
    step();
    expect_flit("post.f0", 8'hB1, 6'd4, 1'b0);
    step();
    expect_flit("post.f1", 8'hB2, 6'd4, 1'b0);
    step();
    expect_flit("post.f2", 8'hB3, 6'd4, 1'b0);
    step();
    expect_flit("post.f3", 8'hB4, 6'd4, 1'b1);
    step();
    check_eq("post.done.send", 32'(send_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
